// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM sequencing controller: Moore FSM, ALU decoder, condition check and NZCV flags.
// Optional MC_EXT_INSTR_EN adds TST, CMN, ADC and LSL/MOV data-processing decodes.
module arm_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUControl,
    output logic [3:0]  State
);

    // state   | meaning
    // FETCH   | read instruction at PC, PC <= PC+4 on last wait cycle
    // DECODE  | read registers, ALU forms PC+8 for R15
    // MEMADR  | base + offset address for LDR/STR
    // MEMRD   | data memory read
    // MEMWB   | load data written to Rd
    // MEMWR   | data memory write on last wait cycle
    // EXECR   | data processing, register operand; flags may update
    // EXECI   | data processing, immediate operand; flags may update
    // ALUWB   | ALU result written to Rd (PC when Rd=15)
    // BRANCH  | PC <= PC+8+offset
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
`ifdef MC_EXT_INSTR_EN
    localparam logic [2:0] ALU_ADC = 3'b100;
    localparam logic [2:0] ALU_LSL = 3'b101;
`endif
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_r_q, cond_ex_r_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       mem_done;

    logic       next_pc, ir_w, reg_w, mem_w, branch, pcs, alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;

    logic [2:0] dec_ctrl;
    logic [1:0] dec_flag_w;
    logic       dec_no_write;
    logic [1:0] flag_w;
    logic       no_write;
    logic       cond_ex, cond_sel;
    logic       n_f, z_f, c_f, v_f;

    logic       unused_instr;

    assign cond         = Instr[31:28];
    assign op           = Instr[27:26];
    assign funct        = Instr[25:20];
    assign rd           = Instr[15:12];
    assign unused_instr = ^{Instr[19:16], Instr[11:0]};
    assign mem_done     = (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            flags_q     <= '0;
            cond_ex_r_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            flags_q     <= flags_d;
            cond_ex_r_q <= cond_ex_r_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        wait_d     = '0;
        next_pc    = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        pcs        = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_done) begin
                    ir_w    = 1'b1;
                    next_pc = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    wait_d  = wait_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                state_d   = funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_done) begin
                    state_d = S_MEMWB;
                end else begin
                    wait_d  = wait_q + 4'd1;
                    state_d = S_MEMRD;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                if (mem_done) begin
                    mem_w = 1'b1;
                end else begin
                    wait_d  = wait_q + 4'd1;
                    state_d = S_MEMWR;
                end
            end
            S_EXECR: begin
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_b = 2'b01;
                alu_op    = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w = 1'b1;
                pcs   = (rd == 4'd15);
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // NoWrite is taken from the held instruction so it still applies in ALUWB,
    // where ALUControl and FlagW have already fallen back to ADD / 00.
    always_comb begin
        dec_ctrl     = ALU_ADD;
        dec_flag_w   = 2'b00;
        dec_no_write = 1'b1;
        case (funct[4:1])
            4'b0100: begin dec_ctrl = ALU_ADD; dec_flag_w = {funct[0], funct[0]}; dec_no_write = 1'b0; end
            4'b0010: begin dec_ctrl = ALU_SUB; dec_flag_w = {funct[0], funct[0]}; dec_no_write = 1'b0; end
            4'b0000: begin dec_ctrl = ALU_AND; dec_flag_w = {funct[0], 1'b0};     dec_no_write = 1'b0; end
            4'b1100: begin dec_ctrl = ALU_ORR; dec_flag_w = {funct[0], 1'b0};     dec_no_write = 1'b0; end
            4'b1010: begin dec_ctrl = ALU_SUB; dec_flag_w = 2'b11; end
`ifdef MC_EXT_INSTR_EN
            4'b1000: begin dec_ctrl = ALU_AND; dec_flag_w = 2'b10; end
            4'b1011: begin dec_ctrl = ALU_ADD; dec_flag_w = 2'b11; end
            4'b0101: begin dec_ctrl = ALU_ADC; dec_flag_w = {funct[0], funct[0]}; dec_no_write = 1'b0; end
            4'b1101: begin dec_ctrl = ALU_LSL; dec_flag_w = {funct[0], 1'b0};     dec_no_write = 1'b0; end
`endif
            default: begin dec_ctrl = ALU_ADD; dec_flag_w = 2'b00; end
        endcase
    end

    assign flag_w   = alu_op ? dec_flag_w : 2'b00;
    assign no_write = (op == 2'b00) & dec_no_write;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        flags_d     = flags_q;
        cond_ex_r_d = cond_ex_r_q;
        if (alu_op) begin
            cond_ex_r_d = cond_ex;
            if (cond_ex && flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (cond_ex && flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // ALUWB must see the condition as it was before EXEC updated the flags.
    assign cond_sel = (state_q == S_ALUWB) ? cond_ex_r_q : cond_ex;

    assign PCWrite    = reset_n & (next_pc | ((pcs | branch) & cond_sel));
    assign IRWrite    = reset_n & ir_w;
    assign RegWrite   = reset_n & reg_w & cond_sel & ~no_write;
    assign MemWrite   = reset_n & mem_w & cond_sel;
    assign AdrSrc     = adr_src;
    assign ALUSrcA    = alu_src_a;
    assign ALUSrcB    = alu_src_b;
    assign ResultSrc  = result_src;
    assign ALUControl = alu_op ? dec_ctrl : ALU_ADD;
    assign ImmSrc     = op;
    assign RegSrc     = {op == 2'b01, op == 2'b10};
    assign State      = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Scoreboard bench for arm_multicycle_ctrl: per-cycle expected records queued by stimulus,
// popped and compared on the falling edge by one monitor per DUT instance.
module tb_arm_multicycle_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, reset2_n;
    logic [31:0] instr0, instr2;
    logic [3:0]  flags0, flags2;

    logic       pcw0, irw0, rw0, mw0, adr0;
    logic [1:0] sa0, sb0, rs0, imm0, rsrc0;
    logic [2:0] ac0;
    logic [3:0] st0;

    logic       pcw2, irw2, rw2, mw2, adr2;
    logic [1:0] sa2, sb2, rs2, imm2, rsrc2;
    logic [2:0] ac2;
    logic [3:0] st2;

    arm_multicycle_ctrl #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .Instr(instr0), .ALUFlags(flags0),
        .PCWrite(pcw0), .IRWrite(irw0), .RegWrite(rw0), .MemWrite(mw0),
        .AdrSrc(adr0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(rs0),
        .ImmSrc(imm0), .RegSrc(rsrc0), .ALUControl(ac0), .State(st0)
    );

    arm_multicycle_ctrl #(.MEM_WAIT(2)) dut2 (
        .clk(clk), .reset_n(reset2_n), .Instr(instr2), .ALUFlags(flags2),
        .PCWrite(pcw2), .IRWrite(irw2), .RegWrite(rw2), .MemWrite(mw2),
        .AdrSrc(adr2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ResultSrc(rs2),
        .ImmSrc(imm2), .RegSrc(rsrc2), .ALUControl(ac2), .State(st2)
    );

    // mask bits: [4] ResultSrc, [3] ALUControl, [2] AdrSrc, [1] ALUSrcA, [0] ALUSrcB
    typedef struct {
        string      nm;
        logic [3:0] st;
        logic [3:0] strb;   // {PCWrite, IRWrite, RegWrite, MemWrite}
        logic [4:0] m;
        logic [1:0] rs;
        logic [2:0] ac;
        logic       adr;
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    exp_t e0, e2;
    int   nvec = 0;
    int   nbad = 0;

`ifdef MC_EXT_INSTR_EN
    localparam logic [2:0] TST_AC = 3'b010;
    localparam logic       TST_Z  = 1'b1;
`else
    localparam logic [2:0] TST_AC = 3'b000;
    localparam logic       TST_Z  = 1'b0;
`endif

    function automatic exp_t mk(string nm, logic [3:0] st, logic [3:0] strb, logic [4:0] m,
                                logic [1:0] rs, logic [2:0] ac, logic adr, logic [1:0] a, logic [1:0] b);
        exp_t e;
        e.nm = nm; e.st = st; e.strb = strb; e.m = m;
        e.rs = rs; e.ac = ac; e.adr = adr; e.a = a; e.b = b;
        return e;
    endfunction

    function automatic exp_t rec_f(string nm, logic [3:0] strb);
        return mk(nm, 4'd0, strb, 5'b11111, 2'b10, 3'b000, 1'b0, 2'b01, 2'b10);
    endfunction

    function automatic exp_t rec_d(string nm);
        return mk(nm, 4'd1, 4'b0000, 5'b10011, 2'b10, 3'b000, 1'b0, 2'b01, 2'b10);
    endfunction

    task automatic check(input exp_t e, input string tag, input logic [3:0] st, input logic [3:0] strb,
                         input logic [1:0] rs, input logic [2:0] ac, input logic adr,
                         input logic [1:0] a, input logic [1:0] b);
        bit bad;
        bad = (st !== e.st) || (strb !== e.strb);
        if (e.m[4] && rs  !== e.rs)  bad = 1'b1;
        if (e.m[3] && ac  !== e.ac)  bad = 1'b1;
        if (e.m[2] && adr !== e.adr) bad = 1'b1;
        if (e.m[1] && a   !== e.a)   bad = 1'b1;
        if (e.m[0] && b   !== e.b)   bad = 1'b1;
        nvec++;
        if (bad) begin
            nbad++;
            $display("FAIL %s/%s @%0t got st=%0d strb=%b rs=%b ac=%b adr=%b a=%b b=%b want st=%0d strb=%b rs=%b ac=%b adr=%b a=%b b=%b mask=%b",
                     tag, e.nm, $time, st, strb, rs, ac, adr, a, b,
                     e.st, e.strb, e.rs, e.ac, e.adr, e.a, e.b, e.m);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            check(e0, "dut0", st0, {pcw0, irw0, rw0, mw0}, rs0, ac0, adr0, sa0, sb0);
        end
    end

    always @(negedge clk) begin
        if (q2.size() > 0) begin
            e2 = q2.pop_front();
            check(e2, "dut2", st2, {pcw2, irw2, rw2, mw2}, rs2, ac2, adr2, sa2, sb2);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data-processing instruction: FETCH, DECODE, EXECR/EXECI, ALUWB.
    task automatic dp(input string nm, input logic [31:0] ins, input logic [3:0] fl,
                      input bit imm, input logic [2:0] ac, input bit rw);
        instr0 = ins;
        flags0 = fl;
        q0.push_back(rec_f({nm, "_f"}, 4'b1100));
        q0.push_back(rec_d({nm, "_d"}));
        q0.push_back(mk({nm, "_ex"}, imm ? 4'd7 : 4'd6, 4'b0000, 5'b01011, 2'b00, ac, 1'b0,
                        2'b00, imm ? 2'b01 : 2'b00));
        q0.push_back(mk({nm, "_wb"}, 4'd8, {2'b00, rw, 1'b0}, 5'b10000, 2'b00, 3'b000, 1'b0, 2'b00, 2'b00));
        cyc(4);
    endtask

    task automatic br(input string nm, input logic [31:0] ins, input bit taken);
        instr0 = ins;
        q0.push_back(rec_f({nm, "_f"}, 4'b1100));
        q0.push_back(rec_d({nm, "_d"}));
        q0.push_back(mk({nm, "_br"}, 4'd9, {taken, 3'b000}, 5'b11011, 2'b10, 3'b000, 1'b0, 2'b00, 2'b01));
        cyc(3);
    endtask

    task automatic mem_front(input string nm, input logic [31:0] ins);
        instr0 = ins;
        flags0 = 4'b0000;
        q0.push_back(rec_f({nm, "_f"}, 4'b1100));
        q0.push_back(rec_d({nm, "_d"}));
        q0.push_back(mk({nm, "_adr"}, 4'd2, 4'b0000, 5'b01011, 2'b00, 3'b000, 1'b0, 2'b00, 2'b01));
    endtask

    initial begin
        reset_n  = 1'b0;
        reset2_n = 1'b0;
        instr0   = 32'h0;
        instr2   = 32'h0;
        flags0   = 4'h0;
        flags2   = 4'h0;

        @(posedge clk);
        #1;
        q0.push_back(rec_f("por0", 4'b0000));
        q0.push_back(rec_f("por1", 4'b0000));
        cyc(2);
        reset_n = 1'b1;

        dp("add_imm", 32'hE2802005, 4'b0000, 1'b1, 3'b000, 1'b1);
        dp("subs",    32'hE0500000, 4'b0100, 1'b0, 3'b001, 1'b1);   // Z becomes 1
        dp("addeq",   32'h02811001, 4'b0000, 1'b1, 3'b000, 1'b1);
        dp("addne",   32'h12811001, 4'b0000, 1'b1, 3'b000, 1'b0);
        dp("subsne",  32'h10500000, 4'b0000, 1'b0, 3'b001, 1'b0);   // skipped, Z stays 1
        dp("addeq2",  32'h02811001, 4'b0000, 1'b1, 3'b000, 1'b1);

        br("b",   32'hEA000001, 1'b1);
        br("bne", 32'h1A000001, 1'b0);

        instr0 = 32'hEC000000;
        q0.push_back(rec_f("op11_f", 4'b1100));
        q0.push_back(rec_d("op11_d"));
        cyc(2);

        mem_front("ldr", 32'hE5902000);
        q0.push_back(mk("ldr_rd", 4'd3, 4'b0000, 5'b00100, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00));
        q0.push_back(mk("ldr_wb", 4'd4, 4'b0010, 5'b10000, 2'b01, 3'b000, 1'b0, 2'b00, 2'b00));
        cyc(5);

        mem_front("str", 32'hE5802014);
        q0.push_back(mk("str_wr", 4'd5, 4'b0001, 5'b00100, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00));
        cyc(4);

        mem_front("strne", 32'h15802014);
        q0.push_back(mk("strne_wr", 4'd5, 4'b0000, 5'b00100, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00));
        cyc(4);

        // Reset lands in the middle of MEMRD; Z=1 beforehand must be cleared.
        mem_front("ldr_rst", 32'hE5902000);
        cyc(3);
        reset_n = 1'b0;
        q0.push_back(rec_f("rst0", 4'b0000));
        q0.push_back(rec_f("rst1", 4'b0000));
        cyc(2);
        reset_n = 1'b1;
        dp("addeq_rst", 32'h02811001, 4'b0000, 1'b1, 3'b000, 1'b0);

        dp("tst",       32'hE1100001, 4'b0100, 1'b0, TST_AC, 1'b0);
        dp("addeq_tst", 32'h02811001, 4'b0000, 1'b1, 3'b000, TST_Z);

        // Slow memory: FETCH and MEMWR each stretch to three cycles.
        instr2   = 32'hE5802014;
        flags2   = 4'b0000;
        reset2_n = 1'b1;
        q2.push_back(rec_f("w2_f0", 4'b0000));
        q2.push_back(rec_f("w2_f1", 4'b0000));
        q2.push_back(rec_f("w2_f2", 4'b1100));
        q2.push_back(rec_d("w2_d"));
        q2.push_back(mk("w2_adr", 4'd2, 4'b0000, 5'b01011, 2'b00, 3'b000, 1'b0, 2'b00, 2'b01));
        q2.push_back(mk("w2_wr0", 4'd5, 4'b0000, 5'b00100, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00));
        q2.push_back(mk("w2_wr1", 4'd5, 4'b0000, 5'b00100, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00));
        q2.push_back(mk("w2_wr2", 4'd5, 4'b0001, 5'b00100, 2'b00, 3'b000, 1'b1, 2'b00, 2'b00));
        q2.push_back(rec_f("w2_f0b", 4'b0000));
        q2.push_back(rec_f("w2_f1b", 4'b0000));
        cyc(10);

        cyc(2);
        nvec++;
        if (q0.size() != 0 || q2.size() != 0) begin
            nbad++;
            $display("FAIL queues_drained got q0=%0d q2=%0d want 0 0", q0.size(), q2.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
